// File: rtl/rf_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
//   Shared register-file geometry, writeback source indices and a small
//   helper for sizing index signals. Imported by the arbiter and its
//   round-robin sub-module.
// -----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  // Width of the wb_src tag; wide enough for up to 8 requesters.
  localparam int WB_SRC_W = 3;

  typedef enum logic [WB_SRC_W-1:0] {
    WB_SRC_ALU = 3'd0,
    WB_SRC_MEM = 3'd1,
    WB_SRC_MUL = 3'd2
  } wb_src_e;

  // Bits needed to index n items (at least 1).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. The search starts at ptr and
//   rises in index, wrapping from N-1 to 0. Implemented as a double-width
//   masked priority search: the lower copy of req has bits below ptr cleared,
//   the upper copy is unmasked, and the first set bit wins.
// Ports
//   req      in   N    request vector
//   ptr      in   IW   highest-priority index for this cycle
//   gnt      out  N    one-hot grant (all zero when no request)
//   gnt_idx  out  IW   index of the granted request (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int  N  = 3,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [2*N-1:0] masked;
  logic           found;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    masked  = {req, req};
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;

    for (int j = 0; j < N; j++) begin
      if (IW'(j) < ptr) masked[j] = 1'b0;
    end

    // Lowest set bit of the doubled vector is the next requester at or
    // after ptr; hits in the upper half are the wrapped-around ones.
    for (int j = 0; j < 2*N; j++) begin
      if (!found && masked[j]) begin
        found   = 1'b1;
        gnt_idx = (j >= N) ? IW'(j - N) : IW'(j);
      end
    end

    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single register-file write port among NREQ writeback sources
//   with round-robin arbitration. The accepted request is registered into the
//   rf_* output stage one cycle later. pend_mask tells the issue stage which
//   registers have a write waiting or in flight.
// Ports
//   clk        in   1          clock, all state on posedge
//   reset      in   1          asynchronous, active-high reset
//   req_valid  in   NREQ       per-source write request
//   req_ready  out  NREQ       per-source accept, one-hot or zero (comb)
//   req_waddr  in   NREQ*AW    packed dest regs, source i at [i*AW +: AW]
//   req_wdata  in   NREQ*DW    packed data, source i at [i*DW +: DW]
//   rf_we      out  1          regfile write enable (registered)
//   rf_waddr   out  AW         regfile write address (registered)
//   rf_wdata   out  DW         regfile write data (registered)
//   wb_src     out  3          source owning the current rf_* write
//   pend_mask  out  2**AW      bit r set = write to reg r waiting/in flight
// -----------------------------------------------------------------------------
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int  NREQ = 3,
  parameter int  AW   = RF_AW,
  parameter int  DW   = RF_DW,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_waddr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [WB_SRC_W-1:0]  wb_src,
  output logic [2**AW-1:0]     pend_mask
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   next_ptr;
  logic [NREQ-1:0] gnt;
  logic            accept;
  logic [AW-1:0]   sel_waddr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_live;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // No source may see ready while reset holds the output stage clear.
  assign req_ready = reset ? '0 : gnt;
  assign accept    = |gnt;
  assign next_ptr  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  // One-hot mux of the granted source's address and data.
  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_waddr = req_waddr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Writes to r0 are accepted but never reach the regfile.
  assign sel_live = accept && (sel_waddr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_src   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      rf_we    <= sel_live;
      // The regfile forwards wdata on an address match without looking at
      // we, so the idle output stage must park at address 0 with zero data.
      rf_waddr <= sel_live ? sel_waddr : '0;
      rf_wdata <= sel_live ? sel_wdata : '0;
      if (accept) begin
        rr_ptr <= next_ptr;
        wb_src <= WB_SRC_W'(gnt_idx);
      end
    end
  end

  // Registers with a write in the output stage or still waiting at a source.
  always_comb begin
    pend_mask = '0;
    if (rf_we) pend_mask[rf_waddr] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) pend_mask[req_waddr[i*AW +: AW]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule
